// File: rtl/uart_tx_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | uart_tx_pkg : shared types and constants for the UART TX controller  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_tx_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = 4;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
// +----------------------------------------------------------------------+
// | uart_tx_ctrl_if : controller <-> serializer handshake                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_tx_ctrl_if;

  logic ser_out;
  logic ser_done;
  logic load;
  logic send;
  logic dont_latch;

  modport master (
    input  ser_out,
    input  ser_done,
    output load,
    output send,
    output dont_latch
  );

  modport slave (
    output ser_out,
    output ser_done,
    input  load,
    input  send,
    input  dont_latch
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_ctrl_parity_calc.sv
// +----------------------------------------------------------------------+
// | parity_calc : parity bit for one payload byte (even/odd selectable)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module parity_calc
  import uart_tx_pkg::*;
(
  input  logic [DATA_BITS-1:0] p_data_i,
  input  logic                 par_typ_i,
  output logic                 par_bit_o
);

  // Even parity makes the total count of ones even; odd inverts that.
  assign par_bit_o = (^p_data_i) ^ (par_typ_i == ODD);

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// +----------------------------------------------------------------------+
// | uart_tx_ctrl : UART transmit framing FSM and serial line mux         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DATA_VALID,
  input  logic [DATA_BITS-1:0] P_DATA,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  uart_tx_ctrl_if.master       ser,
  output logic                 TX_OUT,
  output logic                 busy,
  output logic                 FRAME_ERR
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e            state_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 par_en_q;
  logic                 par_typ_q;
  logic                 par_q;
  logic                 frame_err_q;

  logic w_par_bit;
  logic w_last_stop;
  logic w_accept_win;
  logic w_accept;
  logic unused_par_typ;

  parity_calc u_parity_calc (
    .p_data_i  (P_DATA),
    .par_typ_i (PAR_TYP),
    .par_bit_o (w_par_bit)
  );

  // The last stop cycle doubles as an accept slot so frames can abut.
  assign w_last_stop  = (state_q == STOP) && (stop_cnt_q == LAST_STOP);
  assign w_accept_win = (state_q == IDLE) || w_last_stop;
  assign w_accept     = w_accept_win && DATA_VALID;

  assign ser.load       = w_accept && RST;
  assign ser.dont_latch = !w_accept_win;
  assign ser.send       = (state_q == DATA);

  assign busy           = (state_q != IDLE);
  assign FRAME_ERR      = frame_err_q;
  assign unused_par_typ = par_typ_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      par_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (w_accept) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_q     <= w_par_bit;
      end

      case (state_q)
        IDLE: begin
          if (w_accept) begin
            state_q <= START;
          end
        end

        START: begin
          bit_cnt_q <= '0;
          state_q   <= DATA;
        end

        DATA: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (ser.ser_done) begin
            stop_cnt_q <= 1'b0;
            state_q    <= par_en_q ? PARITY : STOP;
          end else if (bit_cnt_q == LAST_BIT) begin
            // Serializer never signalled completion: flag it, drop parity.
            frame_err_q <= 1'b1;
            stop_cnt_q  <= 1'b0;
            state_q     <= STOP;
          end
        end

        PARITY: begin
          stop_cnt_q <= 1'b0;
          state_q    <= STOP;
        end

        STOP: begin
          if (w_last_stop) begin
            state_q <= w_accept ? START : IDLE;
          end else begin
            stop_cnt_q <= stop_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    TX_OUT = 1'b1;
    case (state_q)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = ser.ser_out;
      PARITY:  TX_OUT = par_q;
      default: TX_OUT = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx_ctrl : directed bench, two controllers (1 and 2 stop bits)|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv    = 1'b0;
  logic       sel   = 1'b0;
  logic       stuck = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       pe = 1'b0;
  logic       pt = 1'b0;

  logic dv1, dv2;
  logic tx1, tx2, busy1, busy2, fe1, fe2;
  logic w_tx, w_busy, w_fe, w_load, w_dl, w_send;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl_if sif1 ();
  uart_tx_ctrl_if sif2 ();

  assign dv1 = dv & ~sel;
  assign dv2 = dv & sel;

  uart_tx_ctrl #(.STOP_BITS(1)) u_dut1 (
    .CLK(clk), .RST(rst_n), .DATA_VALID(dv1), .P_DATA(p_data),
    .PAR_EN(pe), .PAR_TYP(pt), .ser(sif1),
    .TX_OUT(tx1), .busy(busy1), .FRAME_ERR(fe1)
  );

  uart_tx_ctrl #(.STOP_BITS(2)) u_dut2 (
    .CLK(clk), .RST(rst_n), .DATA_VALID(dv2), .P_DATA(p_data),
    .PAR_EN(pe), .PAR_TYP(pt), .ser(sif2),
    .TX_OUT(tx2), .busy(busy2), .FRAME_ERR(fe2)
  );

  // LSB-first 8-bit serializer models, one per controller
  logic [7:0] sh1 = 8'h00, sh2 = 8'h00;
  logic [2:0] ix1 = 3'd0,  ix2 = 3'd0;

  always @(posedge clk) begin
    if (sif1.load && !sif1.dont_latch) begin
      sh1 <= p_data;
      ix1 <= 3'd0;
    end else if (sif1.send) begin
      ix1 <= ix1 + 3'd1;
    end
  end

  always @(posedge clk) begin
    if (sif2.load && !sif2.dont_latch) begin
      sh2 <= p_data;
      ix2 <= 3'd0;
    end else if (sif2.send) begin
      ix2 <= ix2 + 3'd1;
    end
  end

  assign sif1.ser_out  = sh1[ix1];
  assign sif1.ser_done = sif1.send && (ix1 == 3'd7) && !stuck;
  assign sif2.ser_out  = sh2[ix2];
  assign sif2.ser_done = sif2.send && (ix2 == 3'd7);

  assign w_tx   = sel ? tx2 : tx1;
  assign w_busy = sel ? busy2 : busy1;
  assign w_fe   = sel ? fe2 : fe1;
  assign w_load = sel ? sif2.load : sif1.load;
  assign w_dl   = sel ? sif2.dont_latch : sif1.dont_latch;
  assign w_send = sel ? sif2.send : sif1.send;

  // Present a frame request and check it is accepted on the next edge.
  task automatic accept(input logic [7:0] d, input logic pe_v, input logic pt_v,
                        input logic keep);
    p_data = d; pe = pe_v; pt = pt_v; dv = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (w_load !== 1'b1 || w_dl !== 1'b0) begin
      n_err++;
      $display("FAIL accept: load=%b dont_latch=%b want load=1 dont_latch=0", w_load, w_dl);
    end
    @(posedge clk); #1;
    if (!keep) dv = 1'b0;
  endtask

  // exp is the line sequence in transmit order, one character per cycle.
  task automatic check_frame(input string name, input string exp,
                             input int load_idx, input int pulse_idx, input int drop_idx);
    logic e;
    for (int i = 0; i < exp.len(); i++) begin
      if (i == pulse_idx) dv = 1'b1;
      @(negedge clk);
      e = (exp[i] == "1");
      n_cmp++;
      if (w_tx !== e) begin
        n_err++;
        $display("FAIL %s: TX_OUT cycle %0d got %b want %b", name, i, w_tx, e);
      end
      n_cmp++;
      if (w_busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s: busy cycle %0d got %b want 1", name, i, w_busy);
      end
      n_cmp++;
      if (w_load !== (i == load_idx)) begin
        n_err++;
        $display("FAIL %s: load cycle %0d got %b want %b", name, i, w_load, (i == load_idx));
      end
      @(posedge clk); #1;
      if (i == pulse_idx || i == drop_idx) dv = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (w_busy !== 1'b0 || w_tx !== 1'b1) begin
      n_err++;
      $display("FAIL %s: after frame busy=%b TX_OUT=%b want busy=0 TX_OUT=1", name, w_busy, w_tx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({tx1, busy1, sif1.load, sif1.send, sif1.dont_latch, fe1} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset1: {tx,busy,load,send,dl,fe}=%b want 100000",
               {tx1, busy1, sif1.load, sif1.send, sif1.dont_latch, fe1});
    end
    n_cmp++;
    if ({tx2, busy2, sif2.load, sif2.send, sif2.dont_latch, fe2} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset2: {tx,busy,load,send,dl,fe}=%b want 100000",
               {tx2, busy2, sif2.load, sif2.send, sif2.dont_latch, fe2});
    end
    p_data = 8'hA5; pe = 1'b0; pt = 1'b0; dv = 1'b1;
    #1;
    n_cmp++;
    if (w_load !== 1'b0) begin
      n_err++;
      $display("FAIL reset_load: load=%b want 0 while in reset", w_load);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (w_load !== 1'b1) begin
      n_err++;
      $display("FAIL first_accept: load=%b want 1", w_load);
    end
    @(posedge clk); #1;
    dv = 1'b0;
    check_frame("a5_nopar", "0101001011", -1, -1, -1);
  endtask

  task automatic test_parity();
    sel = 1'b0;
    accept(8'hA5, 1'b1, 1'b0, 1'b0);
    check_frame("a5_even", "01010010101", -1, -1, -1);
    accept(8'hA5, 1'b1, 1'b1, 1'b0);
    check_frame("a5_odd", "01010010111", -1, -1, -1);
  endtask

  task automatic test_two_stop();
    sel = 1'b1;
    accept(8'h01, 1'b1, 1'b0, 1'b0);
    check_frame("01_2stop", "010000000111", -1, -1, -1);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    accept(8'h55, 1'b0, 1'b0, 1'b1);
    p_data = 8'hAA;
    check_frame("b2b", "01010101010010101011", 9, -1, 9);
  endtask

  task automatic test_mid_pulse();
    sel = 1'b0;
    accept(8'h3C, 1'b0, 1'b0, 1'b0);
    check_frame("mid_pulse", "0001111001", -1, 4, -1);
  endtask

  task automatic test_frame_err();
    sel = 1'b0;
    n_cmp++;
    if (w_fe !== 1'b0) begin
      n_err++;
      $display("FAIL fe_pre: FRAME_ERR=%b want 0", w_fe);
    end
    stuck = 1'b1;
    accept(8'hA5, 1'b1, 1'b0, 1'b0);
    check_frame("stuck", "0101001011", -1, -1, -1);
    n_cmp++;
    if (w_fe !== 1'b1) begin
      n_err++;
      $display("FAIL fe_set: FRAME_ERR=%b want 1", w_fe);
    end
    stuck = 1'b0;
    accept(8'hA5, 1'b0, 1'b0, 1'b0);
    check_frame("after_err", "0101001011", -1, -1, -1);
    n_cmp++;
    if (w_fe !== 1'b1) begin
      n_err++;
      $display("FAIL fe_sticky: FRAME_ERR=%b want 1", w_fe);
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    accept(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (w_tx !== 1'b0 || w_send !== 1'b1) begin
      n_err++;
      $display("FAIL data_bit3: TX_OUT=%b send=%b want 0 1", w_tx, w_send);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (w_tx !== 1'b1 || w_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: TX_OUT=%b busy=%b want 1 0", w_tx, w_busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (w_tx !== 1'b1 || w_busy !== 1'b0) begin
        n_err++;
        $display("FAIL no_resume: TX_OUT=%b busy=%b want 1 0", w_tx, w_busy);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (w_fe !== 1'b0) begin
      n_err++;
      $display("FAIL fe_clear: FRAME_ERR=%b want 0", w_fe);
    end
    accept(8'hA5, 1'b1, 1'b0, 1'b0);
    check_frame("post_rst", "01010010101", -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_mid_pulse();
    test_frame_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
